// File: rtl/debounce_sync_if.sv
// Signal bundle between a bouncy-input source and the debounce/synchronizer block.
// The master drives the raw input and sample strobe; the slave returns the clean level and edge strobes.
interface debounce_sync_if;
  logic raw_in;
  logic tick;
  logic d_clean;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output raw_in,
    output tick,
    input  d_clean,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  raw_in,
    input  tick,
    output d_clean,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/debounce_sync.sv
// Synchronizer chain, then a counter-qualified debounce FSM, then one-cycle edge strobes.
//   state       | meaning
//   S_LOW       | d_clean=0, input agrees with it
//   S_WAIT_HIGH | d_clean=0, counting tick-qualified 1 samples
//   S_HIGH      | d_clean=1, input agrees with it
//   S_WAIT_LOW  | d_clean=1, counting tick-qualified 0 samples
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_sync_if.slave  dbif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_in;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   d_clean_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dbif.raw_in};
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      d_clean_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (s_in && dbif.tick) begin
            // A single required sample commits straight away.
            if (STABLE_CYCLES == 1) begin
              state_q   <= S_HIGH;
              d_clean_q <= 1'b1;
              rise_q    <= 1'b1;
            end else begin
              state_q <= S_WAIT_HIGH;
              cnt_q   <= CNT_ONE;
              busy_q  <= 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (!s_in) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (dbif.tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q   <= S_HIGH;
              cnt_q     <= '0;
              busy_q    <= 1'b0;
              d_clean_q <= 1'b1;
              rise_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        S_HIGH: begin
          if (!s_in && dbif.tick) begin
            if (STABLE_CYCLES == 1) begin
              state_q   <= S_LOW;
              d_clean_q <= 1'b0;
              fall_q    <= 1'b1;
            end else begin
              state_q <= S_WAIT_LOW;
              cnt_q   <= CNT_ONE;
              busy_q  <= 1'b1;
            end
          end
        end
        S_WAIT_LOW: begin
          if (s_in) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (dbif.tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q   <= S_LOW;
              cnt_q     <= '0;
              busy_q    <= 1'b0;
              d_clean_q <= 1'b0;
              fall_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= S_LOW;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dbif.d_clean    = d_clean_q;
  assign dbif.rise_pulse = rise_q;
  assign dbif.fall_pulse = fall_q;
  assign dbif.busy       = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: run-length reference model compared every cycle, plus directed latency checks.
`timescale 1ns/1ps
module tb_debounce_sync;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  debounce_sync_if dbif();

  debounce_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dbif (dbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: s_in is raw_in delayed by SYNC_STAGES edges; d_clean flips once the
  // input has disagreed with it for STABLE_CYCLES tick samples with no agreeing sample between.
  logic m_d = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0;
  logic hist[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
        hist.delete();
      end else begin
        logic s;
        s = (hist.size() >= SYNC_STAGES) ? hist[hist.size() - SYNC_STAGES] : 1'b0;
        hist.push_back(dbif.raw_in);
        if (hist.size() > SYNC_STAGES) void'(hist.pop_front());
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s == m_d) begin
          m_run = 0;
        end else if (dbif.tick) begin
          m_run++;
          if (m_run == STABLE_CYCLES) begin
            m_d   = s;
            m_run = 0;
            if (s) m_rise = 1'b1; else m_fall = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if ({dbif.d_clean, dbif.rise_pulse, dbif.fall_pulse, dbif.busy} !==
          {m_d, m_rise, m_fall, (m_run != 0)}) begin
        errors++;
        $display("FAIL cycle_cmp: got d/r/f/b=%b%b%b%b, expected %b%b%b%b at %0t",
                 dbif.d_clean, dbif.rise_pulse, dbif.fall_pulse, dbif.busy,
                 m_d, m_rise, m_fall, (m_run != 0), $time);
      end
    end
  end

  int ek, first_rise, first_fall, n_rise, n_fall, first_busy, last_busy;

  task automatic trk_clear();
    ek = 0; first_rise = 0; first_fall = 0; n_rise = 0; n_fall = 0;
    first_busy = 0; last_busy = 0;
  endtask

  task automatic edge_step(input logic r, input logic t);
    dbif.raw_in = r;
    dbif.tick   = t;
    @(posedge clk);
    #1;
    ek++;
    if (dbif.rise_pulse === 1'b1) begin n_rise++; if (first_rise == 0) first_rise = ek; end
    if (dbif.fall_pulse === 1'b1) begin n_fall++; if (first_fall == 0) first_fall = ek; end
    if (dbif.busy === 1'b1) begin if (first_busy == 0) first_busy = ek; last_busy = ek; end
  endtask

  initial begin
    int base;
    rst_n       = 1'b0;
    dbif.raw_in = 1'b1;
    dbif.tick   = 1'b1;

    // Reset held with raw_in=1: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_outs", int'({dbif.d_clean, dbif.rise_pulse, dbif.fall_pulse, dbif.busy}), 0);
    end
    rst_n = 1'b1;
    trk_clear();
    for (int i = 0; i < 14; i++) edge_step(1'b1, 1'b1);
    chk("rst_release_rise_edge", first_rise, 10);
    chk("rst_release_rise_count", n_rise, 1);

    // Falling step.
    trk_clear();
    for (int i = 0; i < 14; i++) edge_step(1'b0, 1'b1);
    chk("fall_edge", first_fall, 10);
    chk("fall_no_rise", n_rise, 0);
    chk("fall_d_clean", int'(dbif.d_clean), 0);

    // Clean rising step.
    trk_clear();
    for (int i = 0; i < 14; i++) edge_step(1'b1, 1'b1);
    chk("step_rise_edge", first_rise, 10);
    chk("step_rise_count", n_rise, 1);
    chk("step_busy_first", first_busy, 3);
    chk("step_busy_last", last_busy, 9);

    for (int i = 0; i < 14; i++) edge_step(1'b0, 1'b1);

    // Bounce: 5 high, 2 low, then held high.
    trk_clear();
    for (int i = 0; i < 5; i++) edge_step(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) edge_step(1'b0, 1'b1);
    base = ek;
    for (int i = 0; i < 14; i++) edge_step(1'b1, 1'b1);
    chk("bounce_rise_delay", first_rise - base, 10);
    chk("bounce_rise_count", n_rise, 1);

    // Tick every 4th cycle, falling, with a one-sample 1 between ticks aborting the wait.
    trk_clear();
    for (int k = 1; k <= 50; k++) edge_step((k == 13) ? 1'b1 : 1'b0, (k % 4) == 0);
    chk("tick_abort_fall_edge", first_fall, 44);
    chk("tick_abort_fall_count", n_fall, 1);

    // Tick every 4th cycle, rising without interruption.
    trk_clear();
    for (int k = 1; k <= 40; k++) edge_step(1'b1, (k % 4) == 0);
    chk("tick_rise_edge", first_rise, 32);
    chk("tick_rise_count", n_rise, 1);

    // Async reset in the middle of a wait (counter at 5 after edge 7).
    for (int i = 0; i < 14; i++) edge_step(1'b0, 1'b1);
    trk_clear();
    for (int i = 0; i < 7; i++) edge_step(1'b1, 1'b1);
    chk("midwait_busy_before", int'(dbif.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midwait_async_clear", int'({dbif.d_clean, dbif.rise_pulse, dbif.fall_pulse, dbif.busy}), 0);
    trk_clear();
    for (int i = 0; i < 3; i++) edge_step(1'b1, 1'b1);
    chk("midwait_no_pulse", n_rise + n_fall, 0);
    rst_n = 1'b1;
    trk_clear();
    for (int i = 0; i < 14; i++) edge_step(1'b1, 1'b1);
    chk("midwait_release_rise_edge", first_rise, 10);

    // Randomised segments with occasional resets, checked by the per-cycle comparison.
    for (int seg = 0; seg < 300; seg++) begin
      logic r;
      int   hold;
      int   tmode;
      r     = 1'($urandom_range(0, 1));
      hold  = $urandom_range(1, 14);
      tmode = $urandom_range(0, 2);
      if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
      for (int i = 0; i < hold; i++) begin
        logic t;
        t = (tmode == 0) ? 1'b1 : (tmode == 1) ? 1'($urandom_range(0, 1))
                                               : 1'($urandom_range(0, 3) == 0);
        edge_step(r, t);
        rst_n = 1'b1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
